// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op codes, FSM states and op-class helpers for the MDU.
// MDU_MADD_EN widens op to 4 bits to fit the multiply-accumulate codes.
package mult_div_unit_pkg;

  localparam int XLEN = 32;
  localparam int DIV_CYCLES = XLEN;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  localparam logic [OP_W-1:0] mduMult  = OP_W'(0);
  localparam logic [OP_W-1:0] mduMultu = OP_W'(1);
  localparam logic [OP_W-1:0] mduDiv   = OP_W'(2);
  localparam logic [OP_W-1:0] mduDivu  = OP_W'(3);
  localparam logic [OP_W-1:0] mduMthi  = OP_W'(4);
  localparam logic [OP_W-1:0] mduMtlo  = OP_W'(5);
`ifdef MDU_MADD_EN
  localparam logic [OP_W-1:0] mduMadd  = OP_W'(8);
  localparam logic [OP_W-1:0] mduMaddu = OP_W'(9);
  localparam logic [OP_W-1:0] mduMsub  = OP_W'(10);
  localparam logic [OP_W-1:0] mduMsubu = OP_W'(11);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    logic r;
    r = (op == mduMult) || (op == mduMultu);
`ifdef MDU_MADD_EN
    r = r || (op == mduMadd) || (op == mduMaddu)
          || (op == mduMsub) || (op == mduMsubu);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == mduDiv) || (op == mduDivu);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    logic r;
    r = (op == mduMult) || (op == mduDiv);
`ifdef MDU_MADD_EN
    r = r || (op == mduMadd) || (op == mduMsub);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// mdu_divider: 32-step restoring divider on magnitudes, then sign fix-up.
// Divide by zero yields all-ones quotient and the raw dividend as remainder.
module mdu_divider
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] rem, quo, dvs, a_raw;
  logic        neg_q, neg_r, dz, run;
  logic [4:0]  cnt;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, diff;

  // operand magnitudes and one shift-subtract step
  always_comb begin
    a_abs  = (sgn && a[31]) ? -a : a;
    b_abs  = (sgn && b[31]) ? -b : b;
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvs};
  end

  // iterate one quotient bit per cycle; done pulses after the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      run   <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else if (flush) begin
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      quo   <= a_abs;
      dvs   <= b_abs;
      a_raw <= a;
      neg_q <= sgn && (a[31] ^ b[31]);
      neg_r <= sgn && a[31];
      dz    <= (b == '0);
      run   <= 1'b1;
      done  <= 1'b0;
      cnt   <= '0;
    end else if (run) begin
      rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
      quo <= {quo[30:0], ~diff[32]};
      cnt <= cnt + 5'd1;
      if (cnt == 5'(DIV_CYCLES - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // sign fix-up and divide-by-zero override
  always_comb begin
    quotient  = neg_q ? -quo : quo;
    remainder = neg_r ? -rem : rem;
    if (dz) begin
      quotient  = '1;
      remainder = a_raw;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle EX-stage MDU owning HI/LO.
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     A,
  input  logic [31:0]     B,
  input  logic            cancel,
  output logic            busy,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  mdu_state_e      state, state_n;
  logic [OP_W-1:0] op_q;
  logic [31:0]     a_q, b_q;
  logic [3:0]      cnt;
  logic            accept, div_start, commit;
  logic            sgn_q;
  logic [63:0]     ext_a, ext_b, prod, res;
  logic [31:0]     quo, rem;
  logic            div_done;

  assign accept = start && !cancel && (state == S_IDLE);
  assign busy   = (state != S_IDLE);

  mdu_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .flush     (cancel),
    .sgn       (is_signed_op(op)),
    .a         (A),
    .b         (B),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // next state, divider kick and commit strobe
  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    commit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul_op(op): state_n = S_MUL;
            is_div_op(op): begin
              state_n   = S_DIV;
              div_start = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel)                           state_n = S_IDLE;
        else if (cnt == 4'(MUL_CYCLES - 1))   state_n = S_DONE;
      end
      S_DIV: begin
        if (cancel)        state_n = S_IDLE;
        else if (div_done) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
        commit  = !cancel;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // 64-bit product and the value committed into {hi,lo}
  always_comb begin
    sgn_q = is_signed_op(op_q);
    ext_a = {{32{sgn_q & a_q[31]}}, a_q};
    ext_b = {{32{sgn_q & b_q[31]}}, b_q};
    prod  = ext_a * ext_b;
    res   = prod;
    unique case (1'b1)
      is_div_op(op_q): res = {rem, quo};
`ifdef MDU_MADD_EN
      (op_q == mduMadd) || (op_q == mduMaddu): res = {hi, lo} + prod;
      (op_q == mduMsub) || (op_q == mduMsubu): res = {hi, lo} - prod;
`endif
      default: res = prod;
    endcase
  end

  // operand latch, delay counter and HI/LO updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
    end else begin
      if (accept && (is_mul_op(op) || is_div_op(op))) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
        cnt  <= '0;
      end
      if (accept && op == mduMthi) hi <= A;
      if (accept && op == mduMtlo) lo <= A;
      if (state == S_MUL) cnt <= cnt + 4'd1;
      if (commit) {hi, lo} <= res;
    end
  end

endmodule
